axi_ram_arbiter: RTL and testbench

//  Shares one AXI slave (axi_ram) between N_MASTERS sr_cpu_axi cores in the multicore build.
//  - Independent round-robin arbiters on the write path (AW/W/B) and the read path (AR/R).
//  - One outstanding transaction per path; responses are routed by the locked grant, so IDs pass through unchanged.

---
 rtl/axi_ram_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_axi_ram_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_arbiter.sv
// Shares one AXI slave between N_MASTERS cores with independent round-robin write and read arbiters.
// Optional per-master completion counters are enabled by defining AXI_ARB_CNT_EN.
module axi_ram_arbiter #(
  parameter int N_MASTERS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int ID_W_WIDTH = 5,
  parameter int ID_R_WIDTH = 5
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [N_MASTERS-1:0][ID_W_WIDTH-1:0]   s_axi_awid,
  input  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [N_MASTERS-1:0][7:0]              s_axi_awlen,
  input  logic [N_MASTERS-1:0][2:0]              s_axi_awsize,
  input  logic [N_MASTERS-1:0][1:0]              s_axi_awburst,
  input  logic [N_MASTERS-1:0]                   s_axi_awvalid,
  output logic [N_MASTERS-1:0]                   s_axi_awready,
  input  logic [N_MASTERS-1:0][DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [N_MASTERS-1:0][DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic [N_MASTERS-1:0]                   s_axi_wlast,
  input  logic [N_MASTERS-1:0]                   s_axi_wvalid,
  output logic [N_MASTERS-1:0]                   s_axi_wready,
  output logic [N_MASTERS-1:0][ID_W_WIDTH-1:0]   s_axi_bid,
  output logic [N_MASTERS-1:0][1:0]              s_axi_bresp,
  output logic [N_MASTERS-1:0]                   s_axi_bvalid,
  input  logic [N_MASTERS-1:0]                   s_axi_bready,
  input  logic [N_MASTERS-1:0][ID_R_WIDTH-1:0]   s_axi_arid,
  input  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [N_MASTERS-1:0][7:0]              s_axi_arlen,
  input  logic [N_MASTERS-1:0][2:0]              s_axi_arsize,
  input  logic [N_MASTERS-1:0][1:0]              s_axi_arburst,
  input  logic [N_MASTERS-1:0]                   s_axi_arvalid,
  output logic [N_MASTERS-1:0]                   s_axi_arready,
  output logic [N_MASTERS-1:0][ID_R_WIDTH-1:0]   s_axi_rid,
  output logic [N_MASTERS-1:0][DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [N_MASTERS-1:0][1:0]              s_axi_rresp,
  output logic [N_MASTERS-1:0]                   s_axi_rlast,
  output logic [N_MASTERS-1:0]                   s_axi_rvalid,
  input  logic [N_MASTERS-1:0]                   s_axi_rready,
  output logic [ID_W_WIDTH-1:0]                  m_axi_awid,
  output logic [ADDR_WIDTH-1:0]                  m_axi_awaddr,
  output logic [7:0]                             m_axi_awlen,
  output logic [2:0]                             m_axi_awsize,
  output logic [1:0]                             m_axi_awburst,
  output logic                                   m_axi_awvalid,
  input  logic                                   m_axi_awready,
  output logic [DATA_WIDTH-1:0]                  m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]                m_axi_wstrb,
  output logic                                   m_axi_wlast,
  output logic                                   m_axi_wvalid,
  input  logic                                   m_axi_wready,
  input  logic [ID_W_WIDTH-1:0]                  m_axi_bid,
  input  logic [1:0]                             m_axi_bresp,
  input  logic                                   m_axi_bvalid,
  output logic                                   m_axi_bready,
  output logic [ID_R_WIDTH-1:0]                  m_axi_arid,
  output logic [ADDR_WIDTH-1:0]                  m_axi_araddr,
  output logic [7:0]                             m_axi_arlen,
  output logic [2:0]                             m_axi_arsize,
  output logic [1:0]                             m_axi_arburst,
  output logic                                   m_axi_arvalid,
  input  logic                                   m_axi_arready,
  input  logic [ID_R_WIDTH-1:0]                  m_axi_rid,
  input  logic [DATA_WIDTH-1:0]                  m_axi_rdata,
  input  logic [1:0]                             m_axi_rresp,
  input  logic                                   m_axi_rlast,
  input  logic                                   m_axi_rvalid,
  output logic                                   m_axi_rready,
  output logic [N_MASTERS-1:0]                   wr_grant,
  output logic [N_MASTERS-1:0]                   rd_grant
`ifdef AXI_ARB_CNT_EN
  ,
  output logic [N_MASTERS-1:0][15:0]             wr_cnt,
  output logic [N_MASTERS-1:0][15:0]             rd_cnt
`endif
);

  localparam int IDX_W = $clog2(N_MASTERS);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

  wr_state_t        wr_state;
  rd_state_t        rd_state;
  logic [IDX_W-1:0] wr_idx, wr_ptr, wr_pick;
  logic [IDX_W-1:0] rd_idx, rd_ptr, rd_pick;

  // First requester at or after the pointer, wrapping N-1 -> 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      idx = (int'(ptr) + i) % N_MASTERS;
      if (!found && req[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return (int'(idx) == N_MASTERS - 1) ? '0 : idx + IDX_W'(1);
  endfunction

  assign wr_pick = rr_pick(s_axi_awvalid, wr_ptr);
  assign rd_pick = rr_pick(s_axi_arvalid, rd_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= W_IDLE;
      wr_grant <= '0;
      wr_idx   <= '0;
      wr_ptr   <= '0;
    end else begin
      case (wr_state)
        W_IDLE: if (|s_axi_awvalid) begin
          wr_idx   <= wr_pick;
          wr_grant <= N_MASTERS'(1) << wr_pick;
          wr_state <= W_ADDR;
        end
        W_ADDR: if (m_axi_awvalid && m_axi_awready) wr_state <= W_DATA;
        W_DATA: if (m_axi_wvalid && m_axi_wready && m_axi_wlast) wr_state <= W_RESP;
        W_RESP: if (m_axi_bvalid && m_axi_bready) begin
          wr_state <= W_IDLE;
          wr_grant <= '0;
          wr_ptr   <= next_ptr(wr_idx);
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= R_IDLE;
      rd_grant <= '0;
      rd_idx   <= '0;
      rd_ptr   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: if (|s_axi_arvalid) begin
          rd_idx   <= rd_pick;
          rd_grant <= N_MASTERS'(1) << rd_pick;
          rd_state <= R_ADDR;
        end
        R_ADDR: if (m_axi_arvalid && m_axi_arready) rd_state <= R_DATA;
        R_DATA: if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
          rd_state <= R_IDLE;
          rd_grant <= '0;
          rd_ptr   <= next_ptr(rd_idx);
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Valids and readies are gated by the registered state and grant, never by raw requests.
  always_comb begin
    m_axi_awid    = s_axi_awid[wr_idx];
    m_axi_awaddr  = s_axi_awaddr[wr_idx];
    m_axi_awlen   = s_axi_awlen[wr_idx];
    m_axi_awsize  = s_axi_awsize[wr_idx];
    m_axi_awburst = s_axi_awburst[wr_idx];
    m_axi_awvalid = (wr_state == W_ADDR) && s_axi_awvalid[wr_idx];
    m_axi_wdata   = s_axi_wdata[wr_idx];
    m_axi_wstrb   = s_axi_wstrb[wr_idx];
    m_axi_wlast   = s_axi_wlast[wr_idx];
    m_axi_wvalid  = (wr_state == W_DATA) && s_axi_wvalid[wr_idx];
    m_axi_bready  = (wr_state == W_RESP) && s_axi_bready[wr_idx];
    s_axi_awready = (wr_state == W_ADDR && m_axi_awready) ? wr_grant : '0;
    s_axi_wready  = (wr_state == W_DATA && m_axi_wready) ? wr_grant : '0;
    s_axi_bvalid  = (wr_state == W_RESP && m_axi_bvalid) ? wr_grant : '0;
    s_axi_bid     = {N_MASTERS{m_axi_bid}};
    s_axi_bresp   = {N_MASTERS{m_axi_bresp}};

    m_axi_arid    = s_axi_arid[rd_idx];
    m_axi_araddr  = s_axi_araddr[rd_idx];
    m_axi_arlen   = s_axi_arlen[rd_idx];
    m_axi_arsize  = s_axi_arsize[rd_idx];
    m_axi_arburst = s_axi_arburst[rd_idx];
    m_axi_arvalid = (rd_state == R_ADDR) && s_axi_arvalid[rd_idx];
    m_axi_rready  = (rd_state == R_DATA) && s_axi_rready[rd_idx];
    s_axi_arready = (rd_state == R_ADDR && m_axi_arready) ? rd_grant : '0;
    s_axi_rvalid  = (rd_state == R_DATA && m_axi_rvalid) ? rd_grant : '0;
    s_axi_rid     = {N_MASTERS{m_axi_rid}};
    s_axi_rdata   = {N_MASTERS{m_axi_rdata}};
    s_axi_rresp   = {N_MASTERS{m_axi_rresp}};
    s_axi_rlast   = {N_MASTERS{m_axi_rlast}};
  end

`ifdef AXI_ARB_CNT_EN
  // Saturating per-master completion counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (s_axi_bvalid[i] && s_axi_bready[i] && wr_cnt[i] != 16'hFFFF)
          wr_cnt[i] <= wr_cnt[i] + 16'd1;
        if (s_axi_rvalid[i] && s_axi_rready[i] && m_axi_rlast && rd_cnt[i] != 16'hFFFF)
          rd_cnt[i] <= rd_cnt[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_ram_arbiter.sv
// Self-checking bench for axi_ram_arbiter: four bench masters, a behavioural AXI RAM, and
// a routing monitor. Counter checks run when AXI_ARB_CNT_EN is defined.
module tb_axi_ram_arbiter;

  localparam int N   = 4;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0][4:0] s_axi_awid = '0, s_axi_arid = '0, s_axi_bid, s_axi_rid;
  logic [N-1:0][7:0] s_axi_awaddr = '0, s_axi_awlen = '0, s_axi_araddr = '0, s_axi_arlen = '0;
  logic [N-1:0][7:0] s_axi_wdata = '0, s_axi_rdata;
  logic [N-1:0][2:0] s_axi_awsize = '0, s_axi_arsize = '0;
  logic [N-1:0][1:0] s_axi_awburst = '0, s_axi_arburst = '0, s_axi_bresp, s_axi_rresp;
  logic [N-1:0]      s_axi_wstrb = '1;
  logic [N-1:0]      s_axi_awvalid = '0, s_axi_wvalid = '0, s_axi_wlast = '0, s_axi_bready = '0;
  logic [N-1:0]      s_axi_arvalid = '0, s_axi_rready = '0;
  logic [N-1:0]      s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast;

  logic [4:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [7:0] m_axi_awaddr, m_axi_awlen, m_axi_araddr, m_axi_arlen, m_axi_wdata, m_axi_rdata;
  logic [2:0] m_axi_awsize, m_axi_arsize;
  logic [1:0] m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic [0:0] m_axi_wstrb;
  logic       m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic       m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic       m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [N-1:0] wr_grant, rd_grant;
`ifdef AXI_ARB_CNT_EN
  logic [N-1:0][15:0] wr_cnt, rd_cnt;
`endif

  axi_ram_arbiter #(.N_MASTERS(N), .DATA_WIDTH(8), .ADDR_WIDTH(8), .ID_W_WIDTH(5), .ID_R_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .wr_grant(wr_grant), .rd_grant(rd_grant)
`ifdef AXI_ARB_CNT_EN
    , .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
`endif
  );

  // Behavioural RAM: reset loads mem[a] = a ^ 0x5A.
  logic [7:0] mem [256];
  logic [1:0] ws;
  logic [7:0] waddr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws <= 2'd0; m_axi_awready <= 1'b0; m_axi_wready <= 1'b0;
      m_axi_bvalid <= 1'b0; m_axi_bid <= '0; m_axi_bresp <= 2'b00; waddr <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else begin
      case (ws)
        2'd0: begin
          m_axi_awready <= 1'b1;
          if (m_axi_awvalid && m_axi_awready) begin
            waddr <= m_axi_awaddr; m_axi_bid <= m_axi_awid;
            m_axi_awready <= 1'b0; m_axi_wready <= 1'b1; ws <= 2'd1;
          end
        end
        2'd1: if (m_axi_wvalid && m_axi_wready) begin
          if (m_axi_wstrb[0]) mem[waddr] <= m_axi_wdata;
          waddr <= waddr + 8'd1;
          if (m_axi_wlast) begin
            m_axi_wready <= 1'b0; m_axi_bvalid <= 1'b1; ws <= 2'd2;
          end
        end
        default: if (m_axi_bvalid && m_axi_bready) begin
          m_axi_bvalid <= 1'b0; ws <= 2'd0;
        end
      endcase
    end
  end

  logic       rs;
  logic [7:0] raddr, rlen, rcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs <= 1'b0; m_axi_arready <= 1'b0; m_axi_rvalid <= 1'b0; m_axi_rlast <= 1'b0;
      m_axi_rdata <= '0; m_axi_rid <= '0; m_axi_rresp <= 2'b00;
      raddr <= '0; rlen <= '0; rcnt <= '0;
    end else if (!rs) begin
      m_axi_arready <= 1'b1;
      if (m_axi_arvalid && m_axi_arready) begin
        raddr <= m_axi_araddr; rlen <= m_axi_arlen; rcnt <= '0; m_axi_rid <= m_axi_arid;
        m_axi_arready <= 1'b0; m_axi_rvalid <= 1'b1; m_axi_rdata <= mem[m_axi_araddr];
        m_axi_rlast <= (m_axi_arlen == 8'd0); rs <= 1'b1;
      end
    end else if (m_axi_rvalid && m_axi_rready) begin
      if (m_axi_rlast) begin
        m_axi_rvalid <= 1'b0; m_axi_rlast <= 1'b0; rs <= 1'b0;
      end else begin
        raddr <= raddr + 8'd1; rcnt <= rcnt + 8'd1;
        m_axi_rdata <= mem[raddr + 8'd1];
        m_axi_rlast <= (rcnt + 8'd1 == rlen);
      end
    end
  end

  // Monitor: routing/stall rules, grant one-hotness and stability, read grant order log.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0] prev_wr = '0, prev_rd = '0;
  logic [N-1:0] rd_log [64];
  int rd_n = 0;
  int bad_route = 0;
  logic route_bad;
  assign route_bad = ((s_axi_rvalid & ~rd_grant) != 0) || ((s_axi_bvalid & ~wr_grant) != 0) ||
                     ((s_axi_awready & ~wr_grant) != 0) || ((s_axi_wready & ~wr_grant) != 0) ||
                     ((s_axi_arready & ~rd_grant) != 0) || !$onehot0(wr_grant) || !$onehot0(rd_grant) ||
                     (prev_wr != 0 && wr_grant != 0 && wr_grant != prev_wr) ||
                     (prev_rd != 0 && rd_grant != 0 && rd_grant != prev_rd);
  always @(negedge clk) begin
    prev_wr <= wr_grant;
    prev_rd <= rd_grant;
    if (rst_n && route_bad) bad_route <= bad_route + 1;
    if (rd_grant != 0 && prev_rd == 0 && rd_n < 64) begin
      rd_log[rd_n] <= rd_grant;
      rd_n <= rd_n + 1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyReset();
    s_axi_awvalid = '0; s_axi_wvalid = '0; s_axi_bready = '0;
    s_axi_arvalid = '0; s_axi_rready = '0;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic doWrite(input int m, input logic [7:0] addr, input logic [7:0] len,
                         input logic [7:0] d0, input logic [4:0] id,
                         output logic [N-1:0] gnt, output int gcyc, output int dcyc);
    int n;
    @(negedge clk);
    s_axi_awaddr[m] = addr; s_axi_awlen[m] = len; s_axi_awid[m] = id;
    s_axi_awsize[m] = 3'd0; s_axi_awburst[m] = 2'b01; s_axi_awvalid[m] = 1'b1;
    n = 0;
    while (!s_axi_awready[m] && n < TMO) begin @(negedge clk); n++; end
    checkOutput("aw_timeout", 32'(n >= TMO), 32'd0);
    gnt = wr_grant; gcyc = cyc;
    @(posedge clk); #1 s_axi_awvalid[m] = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      s_axi_wdata[m] = d0 + 8'(k); s_axi_wlast[m] = (k == int'(len)); s_axi_wvalid[m] = 1'b1;
      n = 0;
      while (!s_axi_wready[m] && n < TMO) begin @(negedge clk); n++; end
      checkOutput("w_timeout", 32'(n >= TMO), 32'd0);
      @(posedge clk); #1;
    end
    s_axi_wvalid[m] = 1'b0; s_axi_wlast[m] = 1'b0; s_axi_bready[m] = 1'b1;
    n = 0;
    while (!s_axi_bvalid[m] && n < TMO) begin @(negedge clk); n++; end
    checkOutput("b_timeout", 32'(n >= TMO), 32'd0);
    checkOutput("bid", 32'(s_axi_bid[m]), 32'(id));
    dcyc = cyc;
    @(posedge clk); #1 s_axi_bready[m] = 1'b0;
  endtask

  task automatic doRead(input int m, input logic [7:0] addr, input logic [7:0] len,
                        input logic [7:0] exp0, input logic [4:0] id,
                        output logic [N-1:0] gnt, output int gcyc);
    int n, k;
    @(negedge clk);
    s_axi_araddr[m] = addr; s_axi_arlen[m] = len; s_axi_arid[m] = id;
    s_axi_arsize[m] = 3'd0; s_axi_arburst[m] = 2'b01; s_axi_arvalid[m] = 1'b1;
    n = 0;
    while (!s_axi_arready[m] && n < TMO) begin @(negedge clk); n++; end
    checkOutput("ar_timeout", 32'(n >= TMO), 32'd0);
    gnt = rd_grant; gcyc = cyc;
    @(posedge clk); #1 s_axi_arvalid[m] = 1'b0; s_axi_rready[m] = 1'b1;
    k = 0; n = 0;
    while (k <= int'(len) && n < TMO) begin
      @(negedge clk); n++;
      if (s_axi_rvalid[m]) begin
        checkOutput($sformatf("rdata_m%0d_a%0h", m, addr + 8'(k)), 32'(s_axi_rdata[m]), 32'(exp0 + 8'(k)));
        checkOutput("rlast", 32'(s_axi_rlast[m]), 32'(k == int'(len)));
        checkOutput("rid", 32'(s_axi_rid[m]), 32'(id));
        k++;
      end
    end
    checkOutput("r_timeout", 32'(n >= TMO), 32'd0);
    @(posedge clk); #1 s_axi_rready[m] = 1'b0;
  endtask

  typedef struct {
    bit         is_wr;
    int         m;
    logic [7:0] addr;
    logic [7:0] data;
  } vec_t;

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [N-1:0] g;
    int gc, dc;
    if (v.is_wr) doWrite(v.m, v.addr, 8'd0, v.data, 5'(idx), g, gc, dc);
    else         doRead(v.m, v.addr, 8'd0, v.data, 5'(idx), g, gc);
    checkOutput($sformatf("vec%0d_grant", idx), 32'(g), 32'(1 << v.m));
  endtask

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    logic [N-1:0] g0, g1, g2, g3;
    int gc0, gc1, gc2, gc3, dc0, dc3, base, beats, n;

    vecs[0] = '{1'b1, 1, 8'h20, 8'hA5};
    vecs[1] = '{1'b0, 2, 8'h20, 8'hA5};
    vecs[2] = '{1'b1, 0, 8'h21, 8'h3C};
    vecs[3] = '{1'b0, 3, 8'h21, 8'h3C};
    vecs[4] = '{1'b0, 1, 8'h05, 8'h5F};
    vecs[5] = '{1'b1, 2, 8'h06, 8'hFF};
    vecs[6] = '{1'b0, 0, 8'h06, 8'hFF};

    // Test 1: reset with every request asserted.
    s_axi_awvalid = '1; s_axi_arvalid = '1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_m_awvalid", 32'(m_axi_awvalid), 32'd0);
    checkOutput("rst_m_arvalid", 32'(m_axi_arvalid), 32'd0);
    checkOutput("rst_wr_grant", 32'(wr_grant), 32'd0);
    checkOutput("rst_rd_grant", 32'(rd_grant), 32'd0);
    checkOutput("rst_s_ready", 32'({s_axi_awready, s_axi_arready, s_axi_wready}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("first_wr_grant", 32'(wr_grant), 32'b0001);
    checkOutput("first_rd_grant", 32'(rd_grant), 32'b0001);
    applyReset();

    // Test 2: four simultaneous reads served 0,1,2,3 with own data.
    base = rd_n;
    fork
      doRead(0, 8'h10, 8'd0, 8'h10 ^ 8'h5A, 5'd0, g0, gc0);
      doRead(1, 8'h11, 8'd0, 8'h11 ^ 8'h5A, 5'd1, g1, gc1);
      doRead(2, 8'h12, 8'd0, 8'h12 ^ 8'h5A, 5'd2, g2, gc2);
      doRead(3, 8'h13, 8'd0, 8'h13 ^ 8'h5A, 5'd3, g3, gc3);
    join
    checkOutput("rr_count", 32'(rd_n - base), 32'd4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("rr_order%0d", k), 32'(rd_log[(base + k) % 64]), 32'(1 << k));

    // Directed single-beat vectors.
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    // Test 3: concurrent write (core 1) and read (core 2).
    fork
      doWrite(1, 8'h20, 8'd0, 8'hA5, 5'd9, g1, gc1, dc0);
      doRead(2, 8'h30, 8'd0, 8'h30 ^ 8'h5A, 5'd10, g2, gc2);
      begin
        @(negedge clk); @(posedge clk); #1;
        checkOutput("conc_wr_grant", 32'(wr_grant), 32'b0010);
        checkOutput("conc_rd_grant", 32'(rd_grant), 32'b0100);
      end
    join
    doRead(0, 8'h20, 8'd0, 8'hA5, 5'd11, g0, gc0);

    // Test 4: core 0 waits behind core 3's burst.
    fork
      doWrite(3, 8'h40, 8'd3, 8'hC0, 5'd12, g3, gc3, dc3);
      begin
        repeat (2) @(negedge clk);
        doWrite(0, 8'h50, 8'd0, 8'h77, 5'd13, g0, gc0, dc0);
      end
    join
    checkOutput("burst_grant3", 32'(g3), 32'b1000);
    checkOutput("burst_grant0", 32'(g0), 32'b0001);
    checkOutput("core0_waits_b", 32'(gc0 > dc3), 32'd1);
    doRead(1, 8'h40, 8'd3, 8'hC0, 5'd14, g1, gc1);
    doRead(2, 8'h50, 8'd0, 8'h77, 5'd15, g2, gc2);

    // Test 5: reset in the middle of a 4-beat read burst.
    @(negedge clk);
    s_axi_araddr[2] = 8'h60; s_axi_arlen[2] = 8'd3; s_axi_arid[2] = 5'd16; s_axi_arvalid[2] = 1'b1;
    n = 0;
    while (!s_axi_arready[2] && n < TMO) begin @(negedge clk); n++; end
    checkOutput("mid_ar_timeout", 32'(n >= TMO), 32'd0);
    @(posedge clk); #1 s_axi_arvalid[2] = 1'b0; s_axi_rready[2] = 1'b1;
    beats = 0; n = 0;
    while (beats < 2 && n < TMO) begin
      @(negedge clk); n++;
      if (s_axi_rvalid[2]) beats++;
    end
    checkOutput("mid_beats", 32'(beats), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_m_valids", 32'({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'd0);
    checkOutput("midrst_s_rvalid", 32'(s_axi_rvalid), 32'd0);
    checkOutput("midrst_grants", 32'({wr_grant, rd_grant}), 32'd0);
    s_axi_rready[2] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_idle", 32'(rd_grant), 32'd0);
    fork
      doRead(3, 8'h63, 8'd0, 8'h63 ^ 8'h5A, 5'd17, g3, gc3);
      doRead(1, 8'h61, 8'd0, 8'h61 ^ 8'h5A, 5'd18, g1, gc1);
      begin
        @(negedge clk); @(posedge clk); #1;
        checkOutput("rd_ptr_reset", 32'(rd_grant), 32'b0010);
      end
    join

`ifdef AXI_ARB_CNT_EN
    // Test 6: completion counters.
    applyReset();
    for (int i = 0; i < 3; i++) doWrite(2, 8'(8'h70 + i), 8'd0, 8'(i), 5'(i), g2, gc2, dc0);
    doRead(1, 8'h70, 8'd0, 8'h00, 5'd5, g1, gc1);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("wr_cnt%0d", i), 32'(wr_cnt[i]), (i == 2) ? 32'd3 : 32'd0);
      checkOutput($sformatf("rd_cnt%0d", i), 32'(rd_cnt[i]), (i == 1) ? 32'd1 : 32'd0);
    end
`endif

    repeat (2) @(negedge clk);
    checkOutput("routing_monitor", 32'(bad_route), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
